// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle: ID/EX pipeline status towards the sequencer and the
// hold/flush/bubble controls back to the pipeline registers.
interface hazard_ctrl_if #(
  parameter int STAT_W = 32
);
  logic [4:0]        id_ra;
  logic [4:0]        id_rb;
  logic              id_use_ra;
  logic              id_use_rb;
  logic              id_md_start;
  logic              id_hl_read;
  logic [4:0]        ex_rw;
  logic              ex_regWr;
  logic [1:0]        ex_memtoreg;
  logic              ex_redirect;
  logic              pc_stall;
  logic              ifid_stall;
  logic              ifid_flush;
  logic              hazard;
  logic              BranchBubble;
  logic              md_busy;
  logic [STAT_W-1:0] stall_cnt;

  modport master (
    output id_ra, id_rb, id_use_ra, id_use_rb, id_md_start, id_hl_read,
           ex_rw, ex_regWr, ex_memtoreg, ex_redirect,
    input  pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, md_busy, stall_cnt
  );

  modport slave (
    input  id_ra, id_rb, id_use_ra, id_use_rb, id_md_start, id_hl_read,
           ex_rw, ex_regWr, ex_memtoreg, ex_redirect,
    output pc_stall, ifid_stall, ifid_flush, hazard, BranchBubble, md_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer: load-use and mult/div hazard stalls, EX redirect squash,
// multi-cycle mult/div tracking and a saturating stall-cycle counter.
module hazard_ctrl #(
  parameter int MD_LAT = 32,
  parameter int CNT_W  = 6,
  parameter int STAT_W = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  hazard_ctrl_if.slave  bus
);

  typedef enum logic {IDLE, BUSY} md_state_e;

  md_state_e         state_q;
  logic [CNT_W-1:0]  md_cnt_q;
  logic [STAT_W-1:0] stall_cnt_q;
  logic [STAT_W-1:0] stall_cnt_d;

  logic busy;
  logic lu;
  logic sh;
  logic stall;
  logic issue;

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (&v) ? v : v + STAT_W'(1);
  endfunction

  always_comb begin
    busy  = (state_q == BUSY);
    lu    = bus.ex_regWr & (bus.ex_memtoreg == 2'd1) & (bus.ex_rw != 5'd0) &
            ((bus.id_use_ra & (bus.id_ra == bus.ex_rw)) |
             (bus.id_use_rb & (bus.id_rb == bus.ex_rw)));
    sh    = busy & (bus.id_md_start | bus.id_hl_read);
    // A redirect kills the ID instruction, so there is nothing left to stall.
    stall = (lu | sh) & ~bus.ex_redirect;
    issue = bus.id_md_start & ~stall & ~bus.ex_redirect;
    stall_cnt_d = stall ? sat_inc(stall_cnt_q) : stall_cnt_q;
  end

  assign bus.pc_stall     = rst_n & stall;
  assign bus.ifid_stall   = rst_n & stall;
  assign bus.hazard       = rst_n & stall;
  assign bus.ifid_flush   = rst_n & bus.ex_redirect;
  assign bus.BranchBubble = rst_n & bus.ex_redirect;
  assign bus.md_busy      = rst_n & busy;
  assign bus.stall_cnt    = rst_n ? stall_cnt_q : '0;

  // The in-flight op is older than any redirect, so only reset aborts BUSY.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      md_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      case (state_q)
        IDLE: begin
          if (issue) begin
            state_q  <= BUSY;
            md_cnt_q <= CNT_W'(MD_LAT - 1);
          end
        end
        BUSY: begin
          if (md_cnt_q == '0) begin
            state_q <= IDLE;
          end else begin
            md_cnt_q <= md_cnt_q - CNT_W'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
